// File: rtl/display_capture.sv
// Receive-side monitor for a multiplexed 7-segment display. It samples the segment bus and the
// four digit strobes, decodes each settled digit back to a hex nibble, and assembles complete
// four-digit frames.
//
// Ports:
//   clk, reset         system clock; asynchronous active-low reset (released synchronously)
//   dispdig[7:0]       segments [0]=a..[6]=g, [7]=decimal point
//   D1..D4             digit strobes, D1 is the most significant nibble
//   value[15:0]        last complete frame, {D1,D2,D3,D4} nibbles
//   dp[3:0], blank[3:0] per-digit decimal point / dark flags, same order as value
//   frame_valid        one-cycle pulse when value/dp/blank load
//   changed            one-cycle pulse with frame_valid when the frame differs from the last one
//   seg_err            one-cycle pulse: a settled pattern is not a legal digit
//   sel_err            one-cycle pulse: more than one strobe became active
//   stale              level: no digit captured for TIMEOUT cycles
module display_capture #(
    parameter int unsigned SETTLE         = 4,
    parameter int unsigned TIMEOUT        = 4096,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          DIG_ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  dispdig,
    input  logic        D1,
    input  logic        D2,
    input  logic        D3,
    input  logic        D4,
    output logic [15:0] value,
    output logic [3:0]  dp,
    output logic [3:0]  blank,
    output logic        frame_valid,
    output logic        changed,
    output logic        seg_err,
    output logic        sel_err,
    output logic        stale
);
    localparam int unsigned CW = $clog2(SETTLE + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

    // Reset: asserts asynchronously, releases on a clock edge.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    // Two-flop input synchronizers, cleared to the inactive (dark / unstrobed) level.
    logic [7:0] seg_m, seg_s;
    logic [3:0] str_m, str_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_m <= {8{SEG_ACTIVE_LOW}};
            seg_s <= {8{SEG_ACTIVE_LOW}};
            str_m <= {4{DIG_ACTIVE_LOW}};
            str_s <= {4{DIG_ACTIVE_LOW}};
        end else begin
            seg_m <= dispdig;
            seg_s <= seg_m;
            str_m <= {D1, D2, D3, D4};
            str_s <= str_m;
        end
    end

    // Normalised: 1 = lit / strobed. Strobe bit 3 is D1, matching the nibble order of value.
    logic [7:0] seg;
    logic [3:0] str;
    assign seg = SEG_ACTIVE_LOW ? ~seg_s : seg_s;
    assign str = DIG_ACTIVE_LOW ? ~str_s : str_s;

    logic       str_one, str_many;
    logic [1:0] str_idx;
    assign str_one  = (str != 4'b0000) && ((str & (str - 4'd1)) == 4'b0000);
    assign str_many = (str != 4'b0000) && !str_one;

    always_comb begin
        str_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (str[i]) str_idx = 2'(i);
        end
    end

    // {legal, nibble}; an all-dark digit decodes as a legal 0.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h3F:   r = {1'b1, 4'h0};
            7'h06:   r = {1'b1, 4'h1};
            7'h5B:   r = {1'b1, 4'h2};
            7'h4F:   r = {1'b1, 4'h3};
            7'h66:   r = {1'b1, 4'h4};
            7'h6D:   r = {1'b1, 4'h5};
            7'h7D:   r = {1'b1, 4'h6};
            7'h07:   r = {1'b1, 4'h7};
            7'h7F:   r = {1'b1, 4'h8};
            7'h6F:   r = {1'b1, 4'h9};
            7'h77:   r = {1'b1, 4'hA};
            7'h7C:   r = {1'b1, 4'hB};
            7'h39:   r = {1'b1, 4'hC};
            7'h5E:   r = {1'b1, 4'hD};
            7'h79:   r = {1'b1, 4'hE};
            7'h71:   r = {1'b1, 4'hF};
            7'h00:   r = {1'b1, 4'h0};
            default: r = 5'b0_0000;
        endcase
        return r;
    endfunction

    logic [4:0] dec;
    assign dec = seg_decode(seg[6:0]);

    // Capture FSM
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    ref_q, ref_d;
    logic [3:0]    cur_sel;
    logic          eval, capture, multi;

    assign cur_sel = 4'b0001 << idx_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        ref_d   = ref_q;
        eval    = 1'b0;
        capture = 1'b0;
        multi   = 1'b0;
        unique case (state_q)
            StIdle: eval = 1'b1;
            StSettle: begin
                if (str != cur_sel || seg != ref_q) begin
                    eval = 1'b1;
                end else if (cnt_q == CW'(SETTLE)) begin
                    capture = 1'b1;
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StHold: if (str != cur_sel) eval = 1'b1;
            default: state_d = StIdle;
        endcase
        // Idle evaluation, also used the same cycle when SETTLE restarts or HOLD is left.
        if (eval) begin
            state_d = StIdle;
            multi   = str_many;
            if (str_one) begin
                state_d = StSettle;
                cnt_d   = CW'(1);
                idx_d   = str_idx;
                ref_d   = seg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            ref_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ref_q   <= ref_d;
        end
    end

    // Frame assembly
    logic          good, frame_go, multi_q, first_q;
    logic [15:0]   slot_val;
    logic [3:0]    slot_dp, slot_blank, seen_q, seen_d;
    logic [TW-1:0] tcnt_q;

    assign good     = capture && dec[4];
    assign frame_go = (seen_q == 4'hF);
    assign stale    = (tcnt_q == TW'(TIMEOUT));

    // A capture landing on the completion cycle belongs to the next frame.
    always_comb begin
        seen_d = frame_go ? 4'h0 : seen_q;
        if (good) seen_d[idx_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_val    <= '0;
            slot_dp     <= '0;
            slot_blank  <= '0;
            seen_q      <= '0;
            first_q     <= 1'b0;
            multi_q     <= 1'b0;
            value       <= '0;
            dp          <= '0;
            blank       <= '0;
            frame_valid <= 1'b0;
            changed     <= 1'b0;
            seg_err     <= 1'b0;
            sel_err     <= 1'b0;
            tcnt_q      <= '0;
        end else begin
            frame_valid <= frame_go;
            changed     <= frame_go && (!first_q || slot_val != value || slot_dp != dp ||
                                        slot_blank != blank);
            seg_err     <= capture && !dec[4];
            // One pulse per multi-strobe episode rather than one per cycle.
            sel_err     <= multi && !multi_q;
            multi_q     <= multi;
            seen_q      <= seen_d;
            if (frame_go) begin
                value   <= slot_val;
                dp      <= slot_dp;
                blank   <= slot_blank;
                first_q <= 1'b1;
            end
            if (good) begin
                slot_val[{idx_q, 2'b00} +: 4] <= dec[3:0];
                slot_dp[idx_q]                <= seg[7];
                slot_blank[idx_q]             <= (seg[6:0] == 7'h00);
                tcnt_q                        <= '0;
            end else if (!stale) begin
                tcnt_q <= tcnt_q + TW'(1);
            end
        end
    end
endmodule

// File: doc/display_capture.md
Name: display_capture

Overview:
Receive-side counterpart of the multiplexed 7-segment display driver. Samples the segment bus (dispdig) and the four digit strobes (D1..D4), then decodes each strobed digit back to a hex nibble. Assembles the four digits into a 16-bit frame with a one-cycle valid pulse. Used in-system as a self-check monitor on the display pins and in benches as the scoreboard front end for the calculator top level.

Parameters:
SETTLE, 4, clk cycles a single strobe must stay stable before its segments are sampled (min 1)
TIMEOUT, 4096, clk cycles with no captured digit before stale asserts
SEG_ACTIVE_LOW, 0, 1 = segment lines are lit when low
DIG_ACTIVE_LOW, 0, 1 = digit strobes are active when low

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
dispdig  input  8  segments [0]=a..[6]=g, [7]=decimal point
D1  input  1  strobe, digit 1 (most significant nibble)
D2  input  1  strobe, digit 2
D3  input  1  strobe, digit 3
D4  input  1  strobe, digit 4 (least significant nibble)
value  output  16  last complete frame, {D1,D2,D3,D4} nibbles
dp  output  4  decimal-point flags, same order as value
blank  output  4  digit was dark (segments 0x00), same order
frame_valid  output  1  one-cycle pulse when value/dp/blank update
changed  output  1  one-cycle pulse with frame_valid if value/dp/blank differ from the previous frame
seg_err  output  1  one-cycle pulse: sampled pattern is not in the decode table
sel_err  output  1  one-cycle pulse: more than one strobe active after sync
stale  output  1  level: no digit captured for TIMEOUT cycles

Behaviour:
- Reset (async assert, sync release): all outputs 0. Internal slots, seen mask, counters and synchronizers cleared. State = IDLE.
- Inputs pass through a 2-flop synchronizer, then polarity normalization via parameters. Latency is counted from the synchronized signals.
- Decode of {g..a}: 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F. 00 → nibble 0 with blank bit set. Any other pattern → seg_err.
- FSM states: IDLE, SETTLE, HOLD.
  - IDLE: exactly one strobe active → SETTLE, cnt=1, remember strobe index. Zero strobes → stay. More than one strobe → sel_err pulse, stay.
  - SETTLE: strobe set or segment bus changes → restart (back to IDLE evaluation the same cycle, no capture). cnt==SETTLE with bus unchanged → sample segments into the slot; set seen[idx] unless seg_err; → HOLD.
  - HOLD: wait until the strobe deasserts or another single strobe appears. Then → IDLE, or directly → SETTLE for the new strobe. The same strobe is captured at most once per assertion.
- Frame: when seen==1111 after a capture, on the next cycle:
  - value/dp/blank load atomically;
  - frame_valid=1;
  - changed=1 if the new frame differs from the old (the first frame after reset always sets changed);
  - seen clears.
- Re-capture of a slot already set in seen overwrites that slot; the newest sample wins.
- seg_err capture leaves the slot and seen bit unchanged.
- Timeout counter resets on every successful capture and saturates at TIMEOUT.
  - stale=1 while saturated; clears the cycle after the next capture.
  - value holds its last content.
- Simultaneous frame completion and new strobe: both proceed; capture of the new digit targets the next frame.
- Reset mid-SETTLE discards the partial frame; no frame_valid is issued.

Test Plan:
- Cycle D1..D4 (each 8 clk) showing 1,2,3,4 (06,5B,4F,66) → one frame_valid with value=0x1234, changed=1; repeat the sweep → value=0x1234, changed=0.
- Display A,b,C,d with D2 dp lit → value=0xABCD, dp=0100.
- Strobe D3 with segments 0x00 and the rest showing 8 → value=0x8808, blank=0010.
- Pattern 0x01 on D1 → seg_err pulse, no frame until D1 shows valid 7 (07); then value=0x7xxx.
- D1 and D2 both active for 10 clk → sel_err, no capture. Strobe glitch of SETTLE-1 cycles → no capture.
- Hold all strobes inactive for 4096 clk → stale=1. Then one valid digit → stale=0. Assert reset mid-frame → all outputs 0, no frame_valid.
